alu_pipe_responder: RTL and testbench

//  Pipelined, handshaked ALU service unit: accepts (a, b, op) requests, returns z/zero/flags responses.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_pipe_responder_if.sv | 53 +++++
 rtl/alu_core.sv | 59 +++++
 rtl/alu_pipe_responder.sv | 113 +++++++++++
 tb/tb_alu_pipe_responder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, default datapath width and the response flag bundle.
// Imported by the interface, the combinational core and the pipelined responder.
package alu_pkg;

  localparam int ALU_W = 32;
  localparam int OP_W  = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND = 3'b000;
  localparam op_t OP_OR  = 3'b001;
  localparam op_t OP_ADD = 3'b010;
  localparam op_t OP_SUB = 3'b110;
  localparam op_t OP_SLT = 3'b111;

  typedef struct packed {
    logic zero;
    logic cout;
    logic ovf;
    logic ill;
  } alu_flags_t;

  // Flag state of an empty result register: z is 0, so zero reads 1.
  localparam alu_flags_t FLAGS_RST = '{zero: 1'b1, cout: 1'b0, ovf: 1'b0, ill: 1'b0};

  function automatic logic op_is_legal(input op_t op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_pipe_responder_if.sv
// Request/response bundle between an ALU requester (master) and the pipelined responder (slave).
// Both directions use valid/ready; a transfer happens on a rising edge with valid & ready.
interface alu_pipe_responder_if
  import alu_pkg::*;
#(
  parameter int W = ALU_W
);

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  op_t          req_op;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_z;
  logic         rsp_zero;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic         rsp_ill;

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_z,
    output rsp_zero,
    output rsp_cout,
    output rsp_ovf,
    output rsp_ill
  );

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_z,
    input  rsp_zero,
    input  rsp_cout,
    input  rsp_ovf,
    input  rsp_ill
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: (a, b, op) -> (z, zero, cout, ovf, ill).
// ADD and SUB share one W+1-bit adder; SUB feeds ~b with a carry-in of 1.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  op_t          op_i,
  output logic [W-1:0] z_o,
  output alu_flags_t   flags_o
);

  logic         is_sub;
  logic [W-1:0] b_eff;
  logic [W-1:0] and_v;
  logic [W-1:0] or_v;
  logic [W:0]   sum;
  logic         lt_u;
  logic         ovf_as;
  logic [W-1:0] z;
  alu_flags_t   flags;

  assign is_sub = (op_i == OP_SUB);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign and_v[gi] = a_i[gi] & b_i[gi];
    assign or_v[gi]  = a_i[gi] | b_i[gi];
    assign b_eff[gi] = b_i[gi] ^ is_sub;
  end

  // For SUB the carry out of a + ~b + 1 is the unsigned no-borrow indication.
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
  assign lt_u   = (a_i < b_i);
  assign ovf_as = (a_i[W-1] == b_eff[W-1]) && (sum[W-1] != a_i[W-1]);

  always_comb begin
    z     = '0;
    flags = '0;
    case (op_i)
      OP_AND:         z = and_v;
      OP_OR:          z = or_v;
      OP_ADD, OP_SUB: begin
        z          = sum[W-1:0];
        flags.cout = sum[W];
        flags.ovf  = ovf_as;
      end
      OP_SLT:         z = {{(W-1){1'b0}}, lt_u};
      default:        z = '0;
    endcase
    flags.ill  = !op_is_legal(op_i);
    flags.zero = (z == '0);
  end

  assign z_o     = z;
  assign flags_o = flags;

endmodule

// File: rtl/alu_pipe_responder.sv
// Two-stage valid/ready ALU responder: S1 holds operands, S2 holds result and flags.
// One operation per cycle, two in flight at most, strictly in order; counts consumed responses.
module alu_pipe_responder
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  alu_pipe_responder_if.slave bus,
  output logic [CNT_W-1:0]    done_cnt
);

  // Stage 1: accepted request
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;
  op_t          s1_op_q, s1_op_d;

  // Stage 2: computed response
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_z_q, s2_z_d;
  alu_flags_t   s2_flags_q, s2_flags_d;

  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic         s2_adv;
  logic         req_ready;
  logic         accept;
  logic         load_s2;
  logic         rsp_xfer;
  logic [W-1:0] core_z;
  alu_flags_t   core_flags;

  alu_core #(
    .W (W)
  ) u_core (
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .op_i    (s1_op_q),
    .z_o     (core_z),
    .flags_o (core_flags)
  );

  // S2 can take new content when empty or being drained this edge; S1 follows S2.
  assign s2_adv    = !s2_valid_q || bus.rsp_ready;
  assign req_ready = !reset && (!s1_valid_q || s2_adv);
  assign accept    = bus.req_valid && req_ready;
  assign load_s2   = s2_adv && s1_valid_q;
  assign rsp_xfer  = s2_valid_q && bus.rsp_ready;

  always_comb begin
    s1_valid_d = accept || (s1_valid_q && !s2_adv);
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (accept) begin
      s1_a_d  = bus.req_a;
      s1_b_d  = bus.req_b;
      s1_op_d = bus.req_op;
    end
  end

  always_comb begin
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_flags_d = s2_flags_q;
    if (load_s2) begin
      s2_z_d     = core_z;
      s2_flags_d = core_flags;
    end
  end

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (rsp_xfer) begin
      done_cnt_d = done_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_AND;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_flags_q <= FLAGS_RST;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_flags_q <= s2_flags_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_z     = s2_z_q;
  assign bus.rsp_zero  = s2_flags_q.zero;
  assign bus.rsp_cout  = s2_flags_q.cout;
  assign bus.rsp_ovf   = s2_flags_q.ovf;
  assign bus.rsp_ill   = s2_flags_q.ill;
  assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_alu_pipe_responder.sv
// Randomized bench for alu_pipe_responder against an arithmetic reference model and response queue.
// A second instance with a 4-bit counter sees identical stimulus to exercise counter wrap.
module tb_alu_pipe_responder;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] z;
    logic         zero;
    logic         cout;
    logic         ovf;
    logic         ill;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] done_cnt;
  logic [3:0]  done_cnt4;

  always #5 clk = ~clk;

  alu_pipe_responder_if #(.W(W)) bus ();
  alu_pipe_responder_if #(.W(W)) bus4 ();

  alu_pipe_responder #(.W(W), .CNT_W(16)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .done_cnt (done_cnt)
  );

  alu_pipe_responder #(.W(W), .CNT_W(4)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus4),
    .done_cnt (done_cnt4)
  );

  assign bus4.req_valid = bus.req_valid;
  assign bus4.req_a     = bus.req_a;
  assign bus4.req_b     = bus.req_b;
  assign bus4.req_op    = bus.req_op;
  assign bus4.rsp_ready = bus.rsp_ready;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned done_model = 0;
  int unsigned n_rsp = 0;
  rsp_t        exp_q[$];

  logic         rst_prev   = 1'b0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] held_z;
  logic [3:0]   held_f;
  logic         obs_rv, obs_acc, obs_cons;
  rsp_t         obs_rsp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: results from the opcode rules using wide integer arithmetic.
  function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input op_t op);
    rsp_t   r;
    longint sa, sb, sr;
    r  = '{z: '0, zero: 1'b0, cout: 1'b0, ovf: 1'b0, ill: 1'b0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: r.z = a & b;
      3'b001: r.z = a | b;
      3'b010: begin
        r.z    = a + b;
        r.cout = (longint'(a) + longint'(b)) >= 64'h1_0000_0000;
        sr     = sa + sb;
        r.ovf  = (sr != longint'($signed(r.z)));
      end
      3'b110: begin
        r.z    = a - b;
        r.cout = (a >= b);
        sr     = sa - sb;
        r.ovf  = (sr != longint'($signed(r.z)));
      end
      3'b111: r.z = (a < b) ? 32'd1 : 32'd0;
      default: r.ill = 1'b1;
    endcase
    r.zero = (r.z == 0);
    return r;
  endfunction

  // One clock: observe at the falling edge, update the model, return just after the rising edge.
  task automatic cycle();
    logic acc, cons, rst_now;
    rsp_t e;
    @(negedge clk);
    rst_now  = reset;
    acc      = bus.req_valid & bus.req_ready;
    cons     = bus.rsp_valid & bus.rsp_ready;
    obs_rv   = bus.rsp_valid;
    obs_acc  = acc & !rst_now;
    obs_cons = cons & !rst_now;
    obs_rsp  = '{z: bus.rsp_z, zero: bus.rsp_zero, cout: bus.rsp_cout, ovf: bus.rsp_ovf, ill: bus.rsp_ill};
    if (rst_now) chk("rst_req_ready", bus.req_ready, 0);
    if (rst_prev) begin
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_z", bus.rsp_z, 0);
      chk("rst_flags", {bus.rsp_zero, bus.rsp_cout, bus.rsp_ovf, bus.rsp_ill}, 4'b1000);
      if (!rst_now) chk("post_rst_ready", bus.req_ready, 1);
    end
    if (rst_prev || !rst_now) begin
      chk("done_cnt", done_cnt, done_model[15:0]);
      chk("done_cnt4", done_cnt4, done_model[3:0]);
    end
    if (stall_prev && !rst_prev) begin
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_z", bus.rsp_z, held_z);
      chk("stall_flags", {bus.rsp_zero, bus.rsp_cout, bus.rsp_ovf, bus.rsp_ill}, held_f);
    end
    if (cons && !rst_now) begin
      if (exp_q.size() == 0) begin
        chk("stale_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_z", bus.rsp_z, e.z);
        chk("rsp_zero", bus.rsp_zero, e.zero);
        chk("rsp_cout", bus.rsp_cout, e.cout);
        chk("rsp_ovf", bus.rsp_ovf, e.ovf);
        chk("rsp_ill", bus.rsp_ill, e.ill);
      end
      n_rsp++;
      $display("rsp %0d: z=%08h zero=%0b cout=%0b ovf=%0b ill=%0b", n_rsp, bus.rsp_z,
               bus.rsp_zero, bus.rsp_cout, bus.rsp_ovf, bus.rsp_ill);
      done_model++;
    end
    stall_prev = bus.rsp_valid & !bus.rsp_ready & !rst_now;
    held_z     = bus.rsp_z;
    held_f     = {bus.rsp_zero, bus.rsp_cout, bus.rsp_ovf, bus.rsp_ill};
    if (acc && !rst_now) exp_q.push_back(model(bus.req_a, bus.req_b, bus.req_op));
    @(posedge clk);
    #1;
    if (rst_now) begin
      exp_q.delete();
      done_model = 0;
    end
    rst_prev = rst_now;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input op_t op, input logic rr);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.rsp_ready = rr;
    cycle();
  endtask

  // Single op into an idle pipe with rsp_ready=1; checks the two-edge latency.
  task automatic do_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input op_t op);
    drive(1'b1, a, b, op, 1'b1);
    chk({tag, "_acc"}, obs_acc, 1);
    drive(1'b0, '0, '0, OP_AND, 1'b1);
    chk({tag, "_lat1"}, obs_rv, 0);
    drive(1'b0, '0, '0, OP_AND, 1'b1);
    chk({tag, "_lat2"}, obs_rv, 1);
    chk({tag, "_cons"}, obs_cons, 1);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    case ($urandom_range(5))
      0:       return OP_AND;
      1:       return OP_OR;
      2:       return OP_ADD;
      3:       return OP_SUB;
      4:       return OP_SLT;
      default: return op_t'($urandom_range(7));
    endcase
  endfunction

  // Issue n requests (held stable until accepted) with random rsp_ready, then drain.
  task automatic rand_ops(input int n, input int rr_pct);
    int           sent  = 0;
    int           guard = 0;
    logic         pend  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    op_t          op    = OP_AND;
    while ((sent < n || exp_q.size() != 0) && guard < 2000) begin
      if (sent < n && !pend) begin
        a    = rand_opnd();
        b    = rand_opnd();
        op   = rand_op();
        pend = 1'b1;
      end
      drive(pend, a, b, op, ($urandom_range(99) < rr_pct));
      if (obs_acc) begin
        sent++;
        pend = 1'b0;
      end
      guard++;
    end
    chk("drain_in_bound", (guard < 2000), 1);
    chk("all_sent", sent, n);
  endtask

  initial begin
    int base, nacc, ncons;

    // Power-up reset
    reset = 1'b1;
    drive(1'b0, '0, '0, OP_AND, 1'b0);
    drive(1'b0, '0, '0, OP_AND, 1'b0);
    reset = 1'b0;

    // Reset mid-stream with two operations in flight
    drive(1'b1, 32'd1, 32'd2, OP_ADD, 1'b0);
    drive(1'b1, 32'd3, 32'd4, OP_ADD, 1'b0);
    drive(1'b1, 32'd5, 32'd6, OP_ADD, 1'b0);
    chk("full_no_accept", obs_acc, 0);
    chk("full_rsp_valid", obs_rv, 1);
    reset = 1'b1;
    drive(1'b1, 32'd7, 32'd8, OP_ADD, 1'b1);
    drive(1'b1, 32'd7, 32'd8, OP_ADD, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, OP_AND, 1'b1);
      chk("no_stale_after_rst", obs_rv, 0);
    end

    // Directed corner operations
    do_one("add_carry", 32'hFFFF_FFFF, 32'd1, OP_ADD);
    chk("add_carry_z", obs_rsp.z, 32'h0);
    chk("add_carry_f", {obs_rsp.zero, obs_rsp.cout, obs_rsp.ovf, obs_rsp.ill}, 4'b1100);
    do_one("add_ovf", 32'h7FFF_FFFF, 32'd1, OP_ADD);
    chk("add_ovf_z", obs_rsp.z, 32'h8000_0000);
    chk("add_ovf_f", {obs_rsp.zero, obs_rsp.cout, obs_rsp.ovf, obs_rsp.ill}, 4'b0010);
    do_one("sub_borrow", 32'd5, 32'd7, OP_SUB);
    chk("sub_borrow_z", obs_rsp.z, 32'hFFFF_FFFE);
    chk("sub_borrow_f", {obs_rsp.zero, obs_rsp.cout, obs_rsp.ovf, obs_rsp.ill}, 4'b0000);
    do_one("slt_lt", 32'd3, 32'hFFFF_FFFF, OP_SLT);
    chk("slt_lt_z", obs_rsp.z, 32'd1);
    do_one("slt_eq", 32'h1234, 32'h1234, OP_SLT);
    chk("slt_eq_z", obs_rsp.z, 32'd0);
    chk("slt_eq_zero", obs_rsp.zero, 1);
    do_one("illegal", 32'hDEAD_BEEF, 32'h1, 3'b011);
    chk("illegal_z", obs_rsp.z, 32'd0);
    chk("illegal_f", {obs_rsp.zero, obs_rsp.cout, obs_rsp.ovf, obs_rsp.ill}, 4'b1001);

    // Eight back-to-back random ops with 50% consumer back-pressure
    base = int'(done_model);
    rand_ops(8, 50);
    chk("eight_done", done_cnt, base + 8);

    // Streaming with rsp_ready=1: one accept and one response every cycle
    drive(1'b1, rand_opnd(), rand_opnd(), rand_op(), 1'b1);
    drive(1'b1, rand_opnd(), rand_opnd(), rand_op(), 1'b1);
    nacc  = 0;
    ncons = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, $urandom, $urandom, rand_op(), 1'b1);
      nacc  += int'(obs_acc);
      ncons += int'(obs_cons);
    end
    chk("thru_acc", nacc, 20);
    chk("thru_rsp", ncons, 20);
    rand_ops(0, 100);

    // Longer mixed run; the 4-bit counter wraps several times
    rand_ops(30, 70);
    chk("wrap_total", (done_model >= 17), 1);
    chk("wrap4_final", done_cnt4, done_model % 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
